// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the board input conditioner.
package input_cond_pkg;

    // Per-key press-tracking states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } key_st_t;

    // Convert a duration in milliseconds into clock cycles.
    function automatic int ms2cyc(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Larger of two integers, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input bit: 2-FF synchroniser followed by a stability-window debouncer.
// The clean level only changes after the synchronised input has disagreed
// with it for DB_CYC consecutive cycles; `change` pulses in the cycle the
// clean level takes its new value.
module debounce_ch #(
    parameter int   DB_CYC  = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic change
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // Synchronise, then count consecutive cycles of disagreement with the clean level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments everywhere here so every flop samples pre-edge values.
        if (rst) begin
            sync_q <= {2{RST_VAL}};
            stable <= RST_VAL;
            cnt    <= '0;
            change <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            change <= 1'b0;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q[1];
                cnt    <= '0;
                change <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: debounces push buttons and slide switches and turns
// button activity into one-cycle press/release/short/long/auto-repeat events.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int N_KEY       = 4,
    parameter int N_SW        = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_KEY-1:0] KEY,
    input  logic [N_SW-1:0]  sw,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_KEY-1:0] key_short,
    output logic [N_KEY-1:0] key_long,
    output logic [N_KEY-1:0] key_rep,
    output logic [N_SW-1:0]  sw_clean,
    output logic [N_SW-1:0]  sw_change
);

    localparam int DB_CYC   = ms2cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms2cyc(CLK_HZ, LONG_MS);
    localparam int REP_CYC  = ms2cyc(CLK_HZ, REPEAT_MS);

    // Hold counter must reach whichever of the two thresholds is larger.
    localparam int HW = $clog2(max2(LONG_CYC, REP_CYC) + 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC);
    localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC);

    // A zero-length window would make the counters meaningless; refuse to build.
    if (DB_CYC < 1) begin : g_bad_db
        $error("input_conditioner: debounce window is 0 cycles");
    end
    if (LONG_CYC < 1) begin : g_bad_long
        $error("input_conditioner: long-press time is 0 cycles");
    end
    if (REP_CYC < 1) begin : g_bad_rep
        $error("input_conditioner: repeat period is 0 cycles");
    end

    // ------------------------------------------------------------------
    // Push buttons: debounce, then per-key press tracking
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        logic          db_stable;
        logic          db_change;
        logic          lvl;
        logic          rise;
        key_st_t       st_q, st_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          press_d, release_d, short_d, long_d, rep_d;
        logic          level_q, press_q, release_q, short_q, long_q, rep_q;

        // Buttons idle high, so the synchroniser resets to "released".
        debounce_ch #(
            .DB_CYC  (DB_CYC),
            .RST_VAL (1'b1)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .din    (KEY[k]),
            .stable (db_stable),
            .change (db_change)
        );

        assign lvl  = ~db_stable;
        assign rise = db_change & lvl;

        // Next state, hold counter and event pulses for this key.
        always_comb begin
            // NOTE: every signal gets a default first so no path through the case infers a latch.
            st_d      = st_q;
            hcnt_d    = hcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            short_d   = 1'b0;
            long_d    = 1'b0;
            rep_d     = 1'b0;
            case (st_q)
                IDLE: begin
                    if (rise) begin
                        press_d = 1'b1;
                        hcnt_d  = HW'(1);
                        st_d    = PRESS;
                    end
                end
                PRESS: begin
                    // Release wins over reaching the long threshold in the same cycle.
                    if (!lvl) begin
                        release_d = 1'b1;
                        short_d   = 1'b1;
                        st_d      = IDLE;
                    end else if (hcnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                        rep_d  = 1'b1;
                        hcnt_d = HW'(1);
                        st_d   = REPEAT;
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                REPEAT: begin
                    if (!lvl) begin
                        release_d = 1'b1;
                        st_d      = IDLE;
                    end else if (hcnt_q == REP_LAST) begin
                        rep_d  = 1'b1;
                        hcnt_d = HW'(1);
                    end else begin
                        hcnt_d = hcnt_q + HW'(1);
                    end
                end
                default: begin
                    st_d   = IDLE;
                    hcnt_d = '0;
                end
            endcase
        end

        // Register state and outputs; level and its edge pulse leave together.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q      <= IDLE;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
            end else begin
                st_q      <= st_d;
                hcnt_q    <= hcnt_d;
                level_q   <= lvl;
                press_q   <= press_d;
                release_q <= release_d;
                short_q   <= short_d;
                long_q    <= long_d;
                rep_q     <= rep_d;
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_short[k]   = short_q;
        assign key_long[k]    = long_q;
        assign key_rep[k]     = rep_q;
    end

    // ------------------------------------------------------------------
    // Slide switches: debounce only, retimed to match the key path
    // ------------------------------------------------------------------
    for (genvar s = 0; s < N_SW; s++) begin : g_sw
        logic db_stable;
        logic db_change;
        logic clean_q;
        logic change_q;

        debounce_ch #(
            .DB_CYC  (DB_CYC),
            .RST_VAL (1'b0)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .din    (sw[s]),
            .stable (db_stable),
            .change (db_change)
        );

        // Output register so switch and key events share the same latency.
        always_ff @(posedge clk) begin
            if (rst) begin
                clean_q  <= 1'b0;
                change_q <= 1'b0;
            end else begin
                clean_q  <= db_stable;
                change_q <= db_change;
            end
        end

        assign sw_clean[s]  = clean_q;
        assign sw_change[s] = change_q;
    end

endmodule
